// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit 7-segment scan controller with frame-synchronous double buffering
// Optional lamp test after reset: define SEG_LAMPTEST_EN.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned LAMP_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic        neg,
    input  logic        blank_lz,
    output logic        ready,
    output logic        ovf,
    output logic [1:0]  en,
    output logic [3:0]  num
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("seg_scan_ctrl: REFRESH_DIV must be at least 2");
    end
    if (LAMP_FRAMES < 1) begin : g_bad_lamp
        $error("seg_scan_ctrl: LAMP_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_LAMP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         en_q;
    logic [3:0]         num_q;
    logic               ready_q;
    logic               ovf_q;
    logic [15:0]        sh_digits_q;
    logic               sh_neg_q;
    logic               sh_blank_q;
    logic [15:0]        pd_digits_q;
    logic               pd_neg_q;
    logic               pd_blank_q;

    logic               tick;
    logic               frame_end;
    logic [1:0]         en_d;
    logic [3:0]         num_d;
    logic               ovf_d;
    logic [15:0]        sh_digits_d;
    logic               sh_neg_d;
    logic               sh_blank_d;
    logic               lamp_show;

`ifdef SEG_LAMPTEST_EN
    localparam int unsigned LW = $clog2(LAMP_FRAMES + 1);
    logic [LW-1:0]      lamp_cnt_q;
    logic               lamp_last;
    assign lamp_last = (lamp_cnt_q == LW'(LAMP_FRAMES - 1));
`endif

    // Code for one display position; the minus floats just left of the most significant non-zero digit.
    function automatic logic [3:0] seg_code(input logic [15:0] d, input logic n,
                                            input logic b, input logic [1:0] idx);
        logic [1:0] m;
        logic [3:0] nib;
        m = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] != 4'd0) m = 2'(i);
        end
        nib = d[{idx, 2'b00} +: 4];
        if (n && (m != 2'd3) && (idx == m + 2'd1))  seg_code = 4'd10;
        else if (n && (m == 2'd3) && (idx == 2'd3)) seg_code = 4'd10;
        else if (b && (idx > m))                    seg_code = 4'd15;
        else if (nib > 4'd9)                        seg_code = 4'd15;
        else                                        seg_code = nib;
    endfunction

    assign tick      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_end = tick && (en_q == 2'd3);

    always_comb begin
        en_d        = tick ? en_q + 2'd1 : en_q;
        sh_digits_d = sh_digits_q;
        sh_neg_d    = sh_neg_q;
        sh_blank_d  = sh_blank_q;
        if ((state_q == ST_PEND) && frame_end) begin
            sh_digits_d = pd_digits_q;
            sh_neg_d    = pd_neg_q;
            sh_blank_d  = pd_blank_q;
        end
`ifdef SEG_LAMPTEST_EN
        lamp_show = (state_q == ST_LAMP) && !(frame_end && lamp_last);
`else
        lamp_show = 1'b0;
`endif
        num_d = lamp_show ? 4'd8 : seg_code(sh_digits_d, sh_neg_d, sh_blank_d, en_d);
        ovf_d = sh_neg_d && (sh_digits_d[15:12] != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            en_q        <= 2'd0;
            ovf_q       <= 1'b0;
            sh_digits_q <= 16'd0;
            sh_neg_q    <= 1'b0;
            sh_blank_q  <= 1'b1;
            pd_digits_q <= 16'd0;
            pd_neg_q    <= 1'b0;
            pd_blank_q  <= 1'b1;
`ifdef SEG_LAMPTEST_EN
            state_q     <= ST_LAMP;
            ready_q     <= 1'b0;
            num_q       <= 4'd8;
            lamp_cnt_q  <= '0;
`else
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            num_q       <= 4'd0;
`endif
        end else begin
            cnt_q       <= tick ? '0 : cnt_q + CNT_W'(1);
            en_q        <= en_d;
            num_q       <= num_d;
            ovf_q       <= ovf_d;
            sh_digits_q <= sh_digits_d;
            sh_neg_q    <= sh_neg_d;
            sh_blank_q  <= sh_blank_d;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        pd_digits_q <= digits;
                        pd_neg_q    <= neg;
                        pd_blank_q  <= blank_lz;
                        state_q     <= ST_PEND;
                        ready_q     <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (frame_end) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
`ifdef SEG_LAMPTEST_EN
                ST_LAMP: begin
                    if (frame_end) begin
                        if (lamp_last) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            lamp_cnt_q <= lamp_cnt_q + LW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign ovf   = ovf_q;
    assign en    = en_q;
    assign num   = num_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl with REFRESH_DIV=4
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic        neg;
    logic        blank_lz;
    logic        ready;
    logic        ovf;
    logic [1:0]  en;
    logic [3:0]  num;

    int checks = 0;
    int errors = 0;
    logic [15:0] shown;
    int n;

`ifdef SEG_LAMPTEST_EN
    localparam logic [3:0] RST_NUM   = 4'd8;
    localparam logic       RST_READY = 1'b0;
`else
    localparam logic [3:0] RST_NUM   = 4'd0;
    localparam logic       RST_READY = 1'b1;
`endif

    seg_scan_ctrl #(.REFRESH_DIV(4), .LAMP_FRAMES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .digits   (digits),
        .neg      (neg),
        .blank_lz (blank_lz),
        .ready    (ready),
        .ovf      (ovf),
        .en       (en),
        .num      (num)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Expects to be called at a negedge where en=0 has just begun; leaves the bench aligned the same way.
    task automatic read_frame(input string tag, input logic [15:0] exp);
        for (int s = 0; s < 4; s++) begin
            chk({tag, "_en"}, 32'(en), 32'(s));
            chk({tag, "_num"}, 32'(num), 32'(exp[s*4 +: 4]));
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic load_val(input logic [15:0] d, input logic ng, input logic bl);
        digits   = d;
        neg      = ng;
        blank_lz = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        chk("ready_low", 32'(ready), 32'd0);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 200) begin
            chk("hold_old", 32'(num), 32'(shown[en*4 +: 4]));
            @(negedge clk);
            cyc++;
        end
        chk("ready_timeout", 32'(cyc < 200), 32'd1);
        chk("ready_en0", 32'(en), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; digits = 16'd0; neg = 1'b0; blank_lz = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_num", 32'(num), 32'(RST_NUM));
        chk("rst_ready", 32'(ready), 32'(RST_READY));
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

`ifdef SEG_LAMPTEST_EN
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 32; j++) begin
            load   = (j < 30);
            digits = 16'h1234;
            neg    = 1'b1;
            chk("lamp_en", 32'(en), 32'((j / 4) % 4));
            chk("lamp_num", 32'(num), 32'd8);
            chk("lamp_ready", 32'(ready), 32'd0);
            @(negedge clk);
        end
        load = 1'b0;
        chk("lamp_done_ready", 32'(ready), 32'd1);
        read_frame("post_lamp", 16'hFFF0);
`else
        for (int j = 0; j < 32; j++) begin
            chk("idle_en", 32'(en), 32'((j / 4) % 4));
            chk("idle_num", 32'(num), (j / 4) % 4 == 0 ? 32'd0 : 32'd15);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_ovf", 32'(ovf), 32'd0);
            @(negedge clk);
        end
`endif
        shown = 16'hFFF0;

        repeat (5) @(negedge clk);
        load_val(16'h0123, 1'b0, 1'b1);
        wait_ready(n);
        read_frame("v0123", 16'hF123);
        chk("v0123_ovf", 32'(ovf), 32'd0);
        shown = 16'hF123;

        repeat (5) @(negedge clk);
        load_val(16'h0045, 1'b1, 1'b1);
        wait_ready(n);
        read_frame("vm45", 16'hFA45);
        chk("vm45_ovf", 32'(ovf), 32'd0);
        shown = 16'hFA45;

        repeat (5) @(negedge clk);
        load_val(16'h9876, 1'b1, 1'b1);
        wait_ready(n);
        read_frame("vm9876", 16'hA876);
        chk("vm9876_ovf", 32'(ovf), 32'd1);
        shown = 16'hA876;

        repeat (5) @(negedge clk);
        load_val(16'h0000, 1'b1, 1'b1);
        wait_ready(n);
        read_frame("vm0", 16'hFFA0);
        chk("vm0_ovf", 32'(ovf), 32'd0);
        shown = 16'hFFA0;

        repeat (5) @(negedge clk);
        load_val(16'h0007, 1'b0, 1'b0);
        digits = 16'h0555; neg = 1'b1; blank_lz = 1'b1; load = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        wait_ready(n);
        read_frame("v7_nolz", 16'h0007);
        shown = 16'h0007;

        repeat (5) @(negedge clk);
        load_val(16'h0042, 1'b1, 1'b0);
        wait_ready(n);
        read_frame("vm42_nolz", 16'h0A42);
        shown = 16'h0A42;

        repeat (5) @(negedge clk);
        load_val(16'h00A5, 1'b0, 1'b1);
        wait_ready(n);
        read_frame("vA5", 16'hFFF5);
        shown = 16'hFFF5;

        repeat (15) @(negedge clk);
        chk("bnd_en3", 32'(en), 32'd3);
        load_val(16'h0300, 1'b0, 1'b1);
        chk("bnd_en0", 32'(en), 32'd0);
        wait_ready(n);
        chk("bnd_delay", 32'(n), 32'd16);
        read_frame("v300", 16'hF300);
        shown = 16'hF300;

`ifndef SEG_LAMPTEST_EN
        repeat (5) @(negedge clk);
        load_val(16'h0099, 1'b1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstpend_ready", 32'(ready), 32'd1);
        read_frame("rstpend", 16'hFFF0);
        repeat (12) @(negedge clk);
        chk("rstpend_kept", 32'(num), 32'd15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes four 7-segment digits for the signed multiplier result display.
- Drives the `en`/`num` inputs of the seven_segment decoder.
- Accepts a 4-digit BCD magnitude plus sign through a load/ready handshake.
- Double-buffers the value so updates land only on frame boundaries (no tearing), then applies leading-zero blanking and places the minus sign.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays active; legal range ≥ 2.
- LAMP_FRAMES, 8: frames of lamp test after reset; used only with SEG_LAMPTEST_EN.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- load  input  1  request to capture `digits`/`neg`/`blank_lz`; accepted only when `ready`=1.
- digits  input  16  BCD nibbles; [3:0]=digit0 (LSD) … [15:12]=digit3 (MSD).
- neg  input  1  value is negative.
- blank_lz  input  1  enable leading-zero blanking.
- ready  output  1  pending buffer empty; a load is accepted this cycle.
- ovf  output  1  shown value has neg=1 with digit3≠0 (minus overwrites digit3).
- en  output  2  active digit index, goes to seven_segment `en`.
- num  output  4  code for active digit, goes to seven_segment `num`: 0–9 digit, 10 minus, 15 blank.

Behaviour:
- Reset (rst_n=0 at an edge):
  - refresh counter 0; en=0.
  - shadow and pending: digits=0, neg=0, blank_lz=1.
  - ready=1, ovf=0, num=0; display reads "   0".
  - A reset mid-pending drops the pending value.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. tick = (count==REFRESH_DIV-1).
- Scan: on tick, en advances 0→1→2→3→0. `en` and `num` are registered and change on the same edge.
- Frame boundary: tick while en==3.
- Update FSM, two states:
  - IDLE (ready=1): load=1 captures inputs into pending; go to PEND.
  - PEND (ready=0): load is ignored. On frame boundary, pending→shadow; go to IDLE.
  - ready rises the cycle after the boundary.
  - New shadow values appear on `num` at the en=0 slot that starts at that boundary edge.
  - A load accepted in the same cycle as a boundary waits for the next boundary.
- ovf: registered from shadow; updates with the shadow copy.
- num mapping for digit i, from shadow:
  - Nibble >9 → 15.
  - MSD index m = highest i with nibble≠0; m=0 if all zero.
  - If blank_lz=1: digits i>m → 15; digit0 never blanked.
  - If neg=1 and m<3: digit m+1 → 10 (minus floats left of MSD). If blank_lz=0, the minus still goes at m+1 and replaces that zero.
  - If neg=1 and m=3: digit3 → 10 and ovf=1.
  - Negative zero ("-0"): shows minus at digit1.
- num is recomputed each cycle for the next en value and registered with en, so en and num are always consistent.

Optional Feature:
- Macro: SEG_LAMPTEST_EN.
- Defined:
  - After reset, num=8 on every digit for LAMP_FRAMES full frames; scan runs normally.
  - ready=0 throughout and loads are ignored.
  - At the end of the last lamp frame, display switches to shadow and ready=1 the next cycle.
  - Reset during lamp test restarts it.
- Undefined: normal operation immediately after reset; LAMP_FRAMES unused.

Test Plan (all with REFRESH_DIV=4):
- Reset then run 32 cycles → en steps 0,1,2,3 every 4 cycles; num = 15,15,15,0 for en=3..0; ready=1, ovf=0.
- load with digits=16'h0123, neg=0, blank_lz=1 mid-frame → ready=0 next cycle; old value shown until boundary; then en0..3 = 3,2,1,15; ready=1 one cycle after boundary.
- load digits=16'h0045, neg=1, blank_lz=1 → after boundary en0..3 = 5,4,10,15; ovf=0.
- load digits=16'h9876, neg=1 → en3=10, ovf=1. Then load 16'h0000, neg=1, blank_lz=1 → en0..3 = 0,10,15,15.
- Second load while ready=0 with different digits → ignored; first value displayed. load asserted exactly on boundary cycle → applied one frame later.
- With SEG_LAMPTEST_EN, LAMP_FRAMES=2 → num=8 on all digits for 32 cycles, ready=0, load ignored; then normal "   0". Reset asserted at cycle 10 restarts the lamp test.
